bsg_wormhole_packet_assembler: RTL
==================================

# bsg_wormhole_packet_assembler

Endpoint stage directly downstream of a `bsg_wormhole_router` output port, typically the P (proc) port. It consumes a wormhole flit stream over a valid/ready link, parses the header flit, and collects the following payload flits into one wide packet. The packet is presented to the local client on a valid/yumi interface. It also counts delivered packets and flags misrouted or oversized packets, so it serves as both an endpoint adapter and a router-integration checker.

## Interface
- `flit_width_p`, 32, width of one flit.
- `cord_width_p`, 8, destination coordinate width. Header bits `[cord_width_p-1:0]`.
- `len_width_p`, 4, payload-length field width. Header bits `[cord_width_p+len_width_p-1:cord_width_p]`.
- `max_payload_flits_p`, 15, payload slots in the output buffer. Must be between 1 and 2^len_width_p-1 inclusive.

Ports (name, direction, width, meaning):
- `clk_i`, in, 1, clock.
- `reset_n_i`, in, 1, reset. Asynchronous assert, active-low.
- `my_cord_i`, in, cord_width_p, this node's coordinate. Quasi-static.
- `v_i`, in, 1, flit valid from router output.
- `data_i`, in, flit_width_p, flit.
- `ready_o`, out, 1, assembler can accept a flit.
- `v_o`, out, 1, assembled packet valid.
- `header_o`, out, flit_width_p, captured header flit.
- `len_o`, out, len_width_p, payload flit count of the packet.
- `payload_o`, out, max_payload_flits_p*flit_width_p, payload slot k at `[k*flit_width_p +: flit_width_p]`.
- `yumi_i`, in, 1, client consumes the packet. Legal only when `v_o`=1.
- `cord_err_o`, out, 1, sticky: some header carried a cord different from `my_cord_i`.
- `len_err_o`, out, 1, sticky: some header carried len > `max_payload_flits_p`.
- `received_o`, out, 32, count of packets consumed via yumi.

## Operation
- A flit transfers on a clock edge where `v_i & ready_o` is high.
- States:
  - IDLE: `ready_o`=1. On a header transfer, capture the header and len, and clear all payload slots to 0. Then:
    - len > max: go to DROP with cnt=len.
    - len = 0: go to DONE.
    - otherwise: go to COLLECT with cnt=0.
  - COLLECT: `ready_o`=1. Each transfer writes `data_i` to slot cnt and increments cnt. The transfer with cnt = len-1 moves the block to DONE.
  - DONE: `ready_o`=0, `v_o`=1. The outputs stay stable until `yumi_i`. On yumi, go to IDLE and increment `received_o`.
  - DROP: `ready_o`=1, `v_o`=0. Each transfer decrements cnt. The transfer at cnt=1 moves the block to IDLE. No packet is delivered and `received_o` is unchanged.
- Error flags:
  - A cord mismatch sets `cord_err_o` when the header is accepted. The packet is still assembled and delivered.
  - `len_err_o` is set when the header is accepted. Flags clear only on reset.
- Counter width: `cnt` is len_width_p bits. `received_o` wraps from 2^32-1 to 0.
- `v_i` while `ready_o`=0 is held by the upstream; the assembler neither samples nor loses it.
- Reset mid-packet discards partial state and returns to IDLE. The router and upstream are reset together, so no orphan payload follows.

## Timing
- Reset (async, `reset_n_i`=0): state IDLE, `ready_o`=0, `v_o`=0, `header_o`/`len_o`/`payload_o`=0, both error flags 0, `received_o`=0, cnt=0.
  - `ready_o` rises the first cycle after deassertion. Deassertion is synchronized to `clk_i` externally.
- All outputs are registered or decoded from state only. There is no combinational path from `v_i`/`data_i`/`yumi_i` to any output.
- Header accepted at edge t with len=N, and one payload flit per cycle: `v_o` is high from cycle t+N+1. A packet with len=0 gives `v_o` at t+1.
- A yumi at edge u drops `v_o` and raises `ready_o` in cycle u+1. The next header is accepted at u+1 at the earliest.
  - Minimum turnaround per packet is therefore N+2 cycles.
- Bubbles (`v_i`=0) in COLLECT or DROP stall cnt. There is no timeout.
- No flit is accepted in DONE, so back-to-back packets never overwrite a pending one.

## Test plan
- Header cord=`my_cord_i`=0x22, len=3, payloads 0xA0,0xA1,0xA2 sent back-to-back, `yumi_i` held high.
  - Required: `v_o` 4 cycles after the header edge, slots 0..2 = A0..A2, slots 3..14 = 0, `received_o`=1, no error flags.
- len=0 header.
  - Required: `v_o` the next cycle with `len_o`=0 and all payload slots 0.
  - Then hold `yumi_i` low for 20 cycles with `v_i` high: `ready_o` stays 0, outputs stable, no flit consumed.
- Header with cord 0x23 ≠ 0x22, len=1.
  - Required: packet delivered and `cord_err_o`=1 permanently after the header edge.
- With `max_payload_flits_p`=4, header len=6 followed by 6 flits, then a valid len=1 packet.
  - Required: `len_err_o`=1, no `v_o` for the first packet, the second packet delivered intact, `received_o`=1.
- len=5 with random `v_i` bubbles and random yumi delay, repeated 1000 packets.
  - Required: every payload matches in order and `received_o`=1000.
- Assert `reset_n_i` after 2 payload flits of a len=4 packet.
  - Required: outputs clear immediately with no clock edge. After release, a fresh len=2 packet assembles correctly.

Source files
------------

// File: rtl/bsg_wormhole_packet_assembler.sv
// Wormhole endpoint: parses a header flit, gathers payload flits into one wide
// packet for a valid/yumi client, and flags misrouted or oversized packets.
module bsg_wormhole_packet_assembler #(
    parameter int flit_width_p        = 32,
    parameter int cord_width_p        = 8,
    parameter int len_width_p         = 4,
    parameter int max_payload_flits_p = 15
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,
    input  logic [cord_width_p-1:0]                     my_cord_i,
    input  logic                                        v_i,
    input  logic [flit_width_p-1:0]                     data_i,
    output logic                                        ready_o,
    output logic                                        v_o,
    output logic [flit_width_p-1:0]                     header_o,
    output logic [len_width_p-1:0]                      len_o,
    output logic [max_payload_flits_p*flit_width_p-1:0] payload_o,
    input  logic                                        yumi_i,
    output logic                                        cord_err_o,
    output logic                                        len_err_o,
    output logic [31:0]                                 received_o
);

    localparam logic [len_width_p-1:0] MAX_LEN = len_width_p'(max_payload_flits_p);
    localparam logic [len_width_p-1:0] LEN_ONE = len_width_p'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE,
        S_DROP
    } state_t;

    state_t                                      r_state;
    logic                                        r_ready;
    logic                                        r_v;
    logic [flit_width_p-1:0]                     r_header;
    logic [len_width_p-1:0]                      r_len;
    logic [len_width_p-1:0]                      r_cnt;
    logic [max_payload_flits_p*flit_width_p-1:0] r_payload;
    logic                                        r_cord_err;
    logic                                        r_len_err;
    logic [31:0]                                 r_received;

    logic                   w_xfer;
    logic [len_width_p-1:0] w_hdr_len;
    logic                   w_last;

    assign w_xfer    = v_i & r_ready;
    assign w_hdr_len = data_i[cord_width_p+len_width_p-1:cord_width_p];
    assign w_last    = (r_cnt == (r_len - LEN_ONE));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_v        <= 1'b0;
            r_header   <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_payload  <= '0;
            r_cord_err <= 1'b0;
            r_len_err  <= 1'b0;
            r_received <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    // ready is held low through reset and comes up here
                    r_ready <= 1'b1;
                    if (w_xfer) begin
                        r_header  <= data_i;
                        r_len     <= w_hdr_len;
                        r_payload <= '0;
                        if (data_i[cord_width_p-1:0] != my_cord_i) begin
                            r_cord_err <= 1'b1;
                        end
                        if (w_hdr_len > MAX_LEN) begin
                            r_len_err <= 1'b1;
                            r_cnt     <= w_hdr_len;
                            r_state   <= S_DROP;
                        end else if (w_hdr_len == '0) begin
                            r_ready <= 1'b0;
                            r_v     <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_xfer) begin
                        for (int k = 0; k < max_payload_flits_p; k++) begin
                            if (r_cnt == k[len_width_p-1:0]) begin
                                r_payload[k*flit_width_p +: flit_width_p] <= data_i;
                            end
                        end
                        r_cnt <= r_cnt + LEN_ONE;
                        if (w_last) begin
                            r_ready <= 1'b0;
                            r_v     <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (yumi_i) begin
                        r_v        <= 1'b0;
                        r_ready    <= 1'b1;
                        r_received <= r_received + 32'd1;
                        r_state    <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt - LEN_ONE;
                        if (r_cnt == LEN_ONE) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o    = r_ready;
    assign v_o        = r_v;
    assign header_o   = r_header;
    assign len_o      = r_len;
    assign payload_o  = r_payload;
    assign cord_err_o = r_cord_err;
    assign len_err_o  = r_len_err;
    assign received_o = r_received;

endmodule
